// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares the single unified RAM port between the instruction-fetch stage and
// the MEM-stage data access (lw/sw). A registered three-state grant FSM
// (IDLE / IGRANT / DGRANT) decides who owns the RAM. Data requests normally
// win. A 4-bit starvation counter forces an instruction grant after
// DSTARVE_MAX consecutive data grants that complete while a fetch is pending.
//
// Optional feature macro: MEM_ARB_STATS_EN
//   Defined   : adds icount/dcount, which count completed fetches and data
//               accesses (wrap at 2^32, cleared by RST).
//   Undefined : no statistics ports or counters.
//
// Ports
//   CLK       in   1   system clock, rising edge
//   RST       in   1   synchronous active-high reset
//   iREN      in   1   instruction read request
//   iaddr     in  32   instruction word address
//   iload     out 32   instruction read data (valid only while iwait is low)
//   iwait     out  1   instruction stall, low for exactly the completing cycle
//   dREN      in   1   data read request
//   dWEN      in   1   data write request (wins over dREN)
//   daddr     in  32   data address
//   dstore    in  32   data write value
//   dload     out 32   data read value (valid only while dwait is low)
//   dwait     out  1   data stall, low for exactly the completing cycle
//   ramREN    out  1   RAM read strobe
//   ramWEN    out  1   RAM write strobe
//   ramaddr   out 32   RAM address
//   ramstore  out 32   RAM write data
//   ramload   in  32   RAM read data
//   ramstate  in   2   RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3
//   icount    out 32   completed fetches      (MEM_ARB_STATS_EN only)
//   dcount    out 32   completed data accesses (MEM_ARB_STATS_EN only)
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int unsigned DSTARVE_MAX = 4  // legal range 1..15
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        iwait,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dwait,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0] icount,
  output logic [31:0] dcount
`endif
);

  typedef enum logic [1:0] {
    RAM_FREE   = 2'd0,
    RAM_BUSY   = 2'd1,
    RAM_ACCESS = 2'd2,
    RAM_ERROR  = 2'd3
  } ram_state_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2
  } arb_state_e;

  localparam logic [3:0] SCNT_MAX = 4'(DSTARVE_MAX);

  arb_state_e r_state;
  arb_state_e w_next_state;
  logic [3:0] r_scnt;

  logic w_dreq;
  logic w_ram_access;
  logic w_icomplete;
  logic w_dcomplete;

  assign w_dreq       = dREN | dWEN;
  assign w_ram_access = (ramstate == RAM_ACCESS);

  // A completion needs the granted side to still be requesting; a withdrawn
  // request (flush) never signals done even if the RAM reports ACCESS.
  assign w_icomplete = (r_state == IGRANT) && iREN   && w_ram_access;
  assign w_dcomplete = (r_state == DGRANT) && w_dreq && w_ram_access;

  // ---------------------------------------------------------------------------
  // State register and starvation counter
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values of its inputs, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_scnt  <= '0;
    end else begin
      r_state <= w_next_state;
      unique case (r_state)
        DGRANT: if (w_dcomplete && iREN && (r_scnt < SCNT_MAX)) r_scnt <= r_scnt + 4'd1;
        IGRANT: if (w_icomplete) r_scnt <= '0;
        default: if (!iREN) r_scnt <= '0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment at the top of each always_comb guarantees
  // every path assigns the output, so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_dreq && (!iREN || (r_scnt < SCNT_MAX))) w_next_state = DGRANT;
        else if (iREN)                                w_next_state = IGRANT;
      end
      IGRANT: if (!iREN || w_ram_access)   w_next_state = IDLE;
      DGRANT: if (!w_dreq || w_ram_access) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic. RAM strobes depend only on state and the granted side's
  // request, never on ramstate; only wait/load react to ramstate.
  // ---------------------------------------------------------------------------
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    unique case (r_state)
      IGRANT: begin
        ramREN  = iREN;
        ramaddr = iaddr;
      end
      DGRANT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
      end
      default: ;
    endcase
  end

  assign iwait = ~w_icomplete;
  assign dwait = ~w_dcomplete;
  assign iload = w_icomplete ? ramload : '0;
  assign dload = w_dcomplete ? ramload : '0;

`ifdef MEM_ARB_STATS_EN
  logic [31:0] r_icount;
  logic [31:0] r_dcount;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_icount <= '0;
      r_dcount <= '0;
    end else begin
      if (w_icomplete) r_icount <= r_icount + 32'd1;
      if (w_dcomplete) r_dcount <= r_dcount + 32'd1;
    end
  end

  assign icount = r_icount;
  assign dcount = r_dcount;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed self-checking bench for mem_arbiter (DSTARVE_MAX = 4). Inputs are
// driven 1 time unit after the rising edge and outputs are sampled 1 unit
// later, well away from the next edge. Compile with +define+MEM_ARB_STATS_EN
// to also check the statistics counters.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        iwait;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] dload;
  logic        dwait;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
`ifdef MEM_ARB_STATS_EN
  logic [31:0] icount;
  logic [31:0] dcount;
`endif

  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;

  int n_checks = 0;
  int n_fail   = 0;

  mem_arbiter #(.DSTARVE_MAX(4)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iload    (iload),
    .iwait    (iwait),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .dload    (dload),
    .dwait    (dwait),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramstate (ramstate)
`ifdef MEM_ARB_STATS_EN
    ,
    .icount   (icount),
    .dcount   (dcount)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ramREN"}, {31'd0, ramREN}, 32'd0);
    check({tag, "_ramWEN"}, {31'd0, ramWEN}, 32'd0);
    check({tag, "_iwait"},  {31'd0, iwait},  32'd1);
    check({tag, "_dwait"},  {31'd0, dwait},  32'd1);
    check({tag, "_iload"},  iload, 32'd0);
    check({tag, "_dload"},  dload, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dn;
    int in;
    int fetches;

    // ---------------- Reset with every request high ----------------
    RST = 1'b1; iREN = 1'b1; dREN = 1'b1; dWEN = 1'b1;
    iaddr = 32'h0000_0010; daddr = 32'h0000_0020; dstore = 32'h1111_1111;
    ramload = 32'h1234_5678; ramstate = ACCESS;
    cyc();
    check_quiet("rst_c1");
    cyc();
    check_quiet("rst_c2");
    check("rst_scnt", {28'd0, dut.r_scnt}, 32'd0);
    RST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; ramstate = FREE;
    cyc();
    check_quiet("idle_after_rst");

    // ---------------- Instruction-only fetch ----------------
    iREN = 1'b1; iaddr = 32'h0000_0040;
    #1;
    check("if_c1_iwait",  {31'd0, iwait},  32'd1);
    check("if_c1_ramREN", {31'd0, ramREN}, 32'd0);
    cyc();
    ramstate = ACCESS; ramload = 32'h2401_0005;
    #1;
    check("if_c2_ramREN",  {31'd0, ramREN}, 32'd1);
    check("if_c2_ramWEN",  {31'd0, ramWEN}, 32'd0);
    check("if_c2_ramaddr", ramaddr, 32'h0000_0040);
    check("if_c2_iwait",   {31'd0, iwait}, 32'd0);
    check("if_c2_iload",   iload, 32'h2401_0005);
    cyc();
    iREN = 1'b0; ramstate = FREE;
    #1;
    check_quiet("if_c3");

    // ---------------- Simultaneous requests: data first ----------------
    iREN = 1'b1; iaddr = 32'h0000_0080;
    dWEN = 1'b1; daddr = 32'h0000_0F00; dstore = 32'hDEAD_BEEF;
    cyc();
    #1;
    check("sim_d_ramWEN",   {31'd0, ramWEN}, 32'd1);
    check("sim_d_ramREN",   {31'd0, ramREN}, 32'd0);
    check("sim_d_ramaddr",  ramaddr,  32'h0000_0F00);
    check("sim_d_ramstore", ramstore, 32'hDEAD_BEEF);
    check("sim_d_dwait_busy", {31'd0, dwait}, 32'd1);
    ramstate = ACCESS; ramload = 32'hCAFE_0001;
    #1;
    check("sim_d_dwait", {31'd0, dwait}, 32'd0);
    check("sim_d_dload", dload, 32'hCAFE_0001);
    check("sim_d_iwait", {31'd0, iwait}, 32'd1);
    cyc();
    dWEN = 1'b0; ramstate = FREE;
    #1;
    check("sim_idle_ramWEN", {31'd0, ramWEN}, 32'd0);
    check("sim_idle_ramREN", {31'd0, ramREN}, 32'd0);
    check("sim_idle_scnt",   {28'd0, dut.r_scnt}, 32'd1);
    cyc();
    #1;
    check("sim_i_ramREN",  {31'd0, ramREN}, 32'd1);
    check("sim_i_ramaddr", ramaddr, 32'h0000_0080);
    check("sim_i_ramstore", ramstore, 32'd0);
    ramstate = ACCESS; ramload = 32'h8C02_0000;
    #1;
    check("sim_i_iwait", {31'd0, iwait}, 32'd0);
    check("sim_i_iload", iload, 32'h8C02_0000);
    cyc();
    iREN = 1'b0; ramstate = FREE;
    #1;
    check("sim_end_scnt",   {28'd0, dut.r_scnt}, 32'd0);
    check("sim_end_ramREN", {31'd0, ramREN}, 32'd0);

    // ---------------- Starvation bound (DSTARVE_MAX = 4) ----------------
    iREN = 1'b1; iaddr = 32'h0000_00C0;
    dREN = 1'b1; dWEN = 1'b1; daddr = 32'h0000_0200; dstore = 32'h0000_55AA;
    ramstate = ACCESS; ramload = 32'h1111_2222;
    #1;
    dn = 0; in = 0;
    for (int i = 0; i < 10; i++) begin
      if (!dwait) dn++;
      if (!iwait) begin
        check("starve_i_after_4d", dn, 32'd4);
        in++;
      end
      if (i == 1) begin
        check("starve_write_wins_wen", {31'd0, ramWEN}, 32'd1);
        check("starve_write_wins_ren", {31'd0, ramREN}, 32'd0);
      end
      if (i == 8) check("starve_scnt_sat", {28'd0, dut.r_scnt}, 32'd4);
      cyc();
    end
    check("starve_dcount", dn, 32'd4);
    check("starve_icount", in, 32'd1);
    check("starve_scnt_clr", {28'd0, dut.r_scnt}, 32'd0);
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; ramstate = FREE;
    cyc();
    check("starve_end_ramREN", {31'd0, ramREN}, 32'd0);

    // ---------------- Wait states then flush ----------------
    dREN = 1'b1; daddr = 32'h0000_0100; ramstate = BUSY; ramload = 32'hABCD_0000;
    cyc();
    for (int k = 0; k < 3; k++) begin
      check("busy_dwait",   {31'd0, dwait},  32'd1);
      check("busy_ramREN",  {31'd0, ramREN}, 32'd1);
      check("busy_ramaddr", ramaddr, 32'h0000_0100);
      check("busy_dload",   dload, 32'd0);
      cyc();
    end
    dREN = 1'b0; ramstate = ACCESS;
    #1;
    check("flush_ramREN", {31'd0, ramREN}, 32'd0);
    check("flush_dwait",  {31'd0, dwait},  32'd1);
    check("flush_dload",  dload, 32'd0);
    cyc();
    check_quiet("flush_idle");
    ramstate = FREE;

    // ---------------- Mid-transaction reset ----------------
    iREN = 1'b1; iaddr = 32'h0000_0044; ramstate = BUSY;
    cyc();
    check("mrst_grant_ramREN", {31'd0, ramREN}, 32'd1);
    RST = 1'b1;
    #1;
    check("mrst_same_cycle_ramREN", {31'd0, ramREN}, 32'd1);
    cyc();
    check_quiet("mrst_after");
    RST = 1'b0; iREN = 1'b0;
    cyc();
    check("mrst_idle_ramREN", {31'd0, ramREN}, 32'd0);
`ifdef MEM_ARB_STATS_EN
    check("stats_icount_rst", icount, 32'd0);
    check("stats_dcount_rst", dcount, 32'd0);
`endif
    iREN = 1'b1; ramstate = ACCESS; ramload = 32'h0000_000F;
    #1;
    fetches = 0;
    for (int i = 0; i < 6; i++) begin
      if (!iwait) fetches++;
      cyc();
    end
    iREN = 1'b0; ramstate = FREE;
    check("three_fetches", fetches, 32'd3);
`ifdef MEM_ARB_STATS_EN
    check("stats_icount_3", icount, 32'd3);
    check("stats_dcount_0", dcount, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
